// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the MAC result collector slice.
//   MAC_RES_W  : width of the MAC running result (low byte of the frame sum)
//   DEF_TERMS  : default number of MAC beats per dot-product frame
//   DEF_EXT_W  : default width of the extended frame sum
//   col_state_t: collector FSM state encoding (ACC=0, CLR=1)
//   entry_w()  : width of one FIFO entry, laid out as {ovf, sum[EXT_W-1:0]}
// ---------------------------------------------------------------------------
package mac_pkg;

    localparam int MAC_RES_W = 8;
    localparam int DEF_TERMS = 4;
    localparam int DEF_EXT_W = 16;

    typedef enum logic {
        ACC = 1'b0,
        CLR = 1'b1
    } col_state_t;

    // A FIFO entry carries the sticky overflow flag in its MSB, directly above
    // the extended sum, so the entry is simply {ovf, sum}.
    function automatic int entry_w(input int ext_w);
        return ext_w + 1;
    endfunction

endpackage

// File: rtl/mac_sum_fifo.sv
// ---------------------------------------------------------------------------
// mac_sum_fifo
// Two-entry valid/ready FIFO for finished frame entries {ovf, sum}.
// The head entry is a register that drives dout directly, so the consumer
// sees stable data while it stalls, and dout keeps its last value once the
// FIFO drains.
// Ports:
//   clk, rst   : clock and asynchronous active-high reset
//   push, din  : write request and entry; a push while full is only taken
//                when the head is popped in the same cycle
//   full       : both entries occupied
//   out_valid  : head entry is valid
//   out_ready  : consumer takes the head on out_valid & out_ready
//   dout       : head entry
// ---------------------------------------------------------------------------
module mac_sum_fifo #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] dout
);

    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic         head_vld;
    logic         tail_vld;
    logic         pop;
    logic         push_ok;

    assign full      = head_vld & tail_vld;
    assign out_valid = head_vld;
    assign dout      = head_q;
    assign pop       = head_vld & out_ready;
    assign push_ok   = push & (~full | pop);

    // The tail only ever holds data while the head is valid, so a pop
    // refills the head from the tail first, then from a same-cycle push.
    // With nothing to refill, the head just goes invalid and its data is
    // held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            head_vld <= 1'b0;
            tail_vld <= 1'b0;
        end else if (pop) begin
            if (tail_vld) begin
                head_q <= tail_q;
                if (push_ok) begin
                    tail_q <= din;
                end else begin
                    tail_vld <= 1'b0;
                end
            end else if (push_ok) begin
                head_q <= din;
            end else begin
                head_vld <= 1'b0;
            end
        end else if (push_ok) begin
            if (!head_vld) begin
                head_q   <= din;
                head_vld <= 1'b1;
            end else begin
                tail_q   <= din;
                tail_vld <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_result_collector.sv
// ---------------------------------------------------------------------------
// mac_result_collector
// Downstream stage of the array-multiplier / Kogge-Stone MAC. It counts the
// MAC's carry-outs over a frame of TERMS beats to extend the 8-bit running
// result to EXT_W bits, queues the finished frame sum in a 2-entry FIFO and
// then pulses mac_clr so the MAC starts the next frame from zero.
// Ports:
//   clk, rst    : clock and asynchronous active-high reset
//   in_valid    : MAC produced a new accumulation this cycle
//   in_ready    : a beat is taken on in_valid & in_ready
//   mac_result  : MAC running result after this beat
//   mac_cout    : this beat's accumulation carried out of bit 7
//   mac_clr     : one-cycle pulse clearing the MAC accumulator
//   out_valid   : FIFO head is valid
//   out_ready   : consumer takes the head on out_valid & out_ready
//   out_sum     : extended frame sum {carry count, mac_result}
//   out_ovf     : the carry counter saturated during this frame
// ---------------------------------------------------------------------------
module mac_result_collector
    import mac_pkg::*;
#(
    parameter int TERMS = DEF_TERMS,
    parameter int EXT_W = DEF_EXT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MAC_RES_W-1:0] mac_result,
    input  logic                 mac_cout,
    output logic                 mac_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXT_W-1:0]     out_sum,
    output logic                 out_ovf
);

    localparam int              HI_W      = EXT_W - MAC_RES_W;
    localparam int              ENTRY_W   = entry_w(EXT_W);
    localparam logic [HI_W-1:0] HI_MAX    = {HI_W{1'b1}};
    localparam logic [7:0]      LAST_BEAT = 8'(TERMS - 1);

    col_state_t         state;
    col_state_t         state_nxt;
    logic [7:0]         beat_cnt;
    logic [HI_W-1:0]    hi_cnt;
    logic               ovf;
    logic [EXT_W-1:0]   pend_sum;
    logic               pend_ovf;

    logic               take;
    logic               last_beat;
    logic               hi_sat;
    logic               bump;
    logic               over;
    logic               fifo_full;
    logic               fifo_push;
    logic [ENTRY_W-1:0] fifo_din;
    logic [ENTRY_W-1:0] fifo_dout;

    // A carry bumps the counter unless it is already saturated; a carry
    // arriving at saturation is what marks the frame as overflowed.
    assign last_beat = (beat_cnt == LAST_BEAT);
    assign hi_sat    = (hi_cnt == HI_MAX);
    assign bump      = mac_cout & ~hi_sat;
    assign over      = mac_cout & hi_sat;

    // Only the closing beat of a frame waits for FIFO space, so mid-frame
    // beats always flow and a finished frame is never dropped.
    assign in_ready  = (state == ACC) & ~(last_beat & fifo_full);
    assign take      = in_valid & in_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and MAC clear: CLR lasts exactly one cycle after the
    // closing beat of every frame.
    always_comb begin
        state_nxt = state;
        mac_clr   = 1'b0;
        case (state)
            ACC: begin
                if (take && last_beat) begin
                    state_nxt = CLR;
                end
            end
            CLR: begin
                mac_clr   = 1'b1;
                state_nxt = ACC;
            end
            default: begin
                state_nxt = ACC;
            end
        endcase
    end

    // Beat and carry counting. The closing beat folds its own carry into
    // the captured entry and resets the counters for the next frame; the
    // captured entry is pushed during the CLR cycle that follows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
            hi_cnt   <= '0;
            ovf      <= 1'b0;
            pend_sum <= '0;
            pend_ovf <= 1'b0;
        end else if (take) begin
            if (last_beat) begin
                pend_sum <= {hi_cnt + HI_W'(bump), mac_result};
                pend_ovf <= ovf | over;
                beat_cnt <= '0;
                hi_cnt   <= '0;
                ovf      <= 1'b0;
            end else begin
                beat_cnt <= beat_cnt + 8'd1;
                hi_cnt   <= hi_cnt + HI_W'(bump);
                if (over) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    assign fifo_push = (state == CLR);
    assign fifo_din  = {pend_ovf, pend_sum};

    mac_sum_fifo #(
        .W (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .din       (fifo_din),
        .full      (fifo_full),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (fifo_dout)
    );

    assign out_ovf = fifo_dout[EXT_W];
    assign out_sum = fifo_dout[EXT_W-1:0];

endmodule

// File: tb/tb_mac_result_collector.sv
// ---------------------------------------------------------------------------
// tb_mac_result_collector
// Directed bench for mac_result_collector. Two instances share the beat
// data: dut uses the default 16-bit extension, dut9 a 9-bit extension so
// the carry counter saturates after a single carry. Expected frame entries
// {ovf, sum} come from a small frame model and wait in a scoreboard queue
// until the DUT presents them.
// ---------------------------------------------------------------------------
module tb_mac_result_collector;

    localparam int TERMS  = 4;
    localparam int BUDGET = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_valid9 = 1'b0;
    logic [7:0]  mac_result = 8'h00;
    logic        mac_cout = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_ready9 = 1'b0;

    logic        in_ready, in_ready9;
    logic        mac_clr, mac_clr9;
    logic        out_valid, out_valid9;
    logic [15:0] out_sum;
    logic [8:0]  out_sum9;
    logic        out_ovf, out_ovf9;

    int checks = 0;
    int errors = 0;

    logic [16:0] q16[$];
    logic [9:0]  q9[$];

    int m_beat[2];
    int m_hi[2];
    bit m_ovf[2];
    int hi_max[2] = '{255, 1};

    mac_result_collector #(.TERMS(TERMS), .EXT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mac_result (mac_result),
        .mac_cout   (mac_cout),
        .mac_clr    (mac_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_ovf    (out_ovf)
    );

    mac_result_collector #(.TERMS(TERMS), .EXT_W(9)) dut9 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid9),
        .in_ready   (in_ready9),
        .mac_result (mac_result),
        .mac_cout   (mac_cout),
        .mac_clr    (mac_clr9),
        .out_valid  (out_valid9),
        .out_ready  (out_ready9),
        .out_sum    (out_sum9),
        .out_ovf    (out_ovf9)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        q16.delete();
        q9.delete();
        for (int s = 0; s < 2; s++) begin
            m_beat[s] = 0;
            m_hi[s]   = 0;
            m_ovf[s]  = 1'b0;
        end
    endtask

    // Present one beat to the selected instance, hold it until taken and
    // run the frame model on the accepted beat. Returns on a falling edge.
    task automatic applyStimulus(input bit sel, input logic [7:0] r, input bit c);
        int  n;
        bit  sat;
        int  hi_f;
        bit  ov;
        mac_result = r;
        mac_cout   = c;
        if (sel) in_valid9 = 1'b1;
        else     in_valid  = 1'b1;
        n = 0;
        while (((sel ? in_ready9 : in_ready) !== 1'b1) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("beat in_ready", {31'b0, (sel ? in_ready9 : in_ready)}, 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_valid9 = 1'b0;
        sat = (m_hi[sel] == hi_max[sel]);
        if (m_beat[sel] == TERMS - 1) begin
            hi_f = m_hi[sel] + ((c && !sat) ? 1 : 0);
            ov   = m_ovf[sel] | (c & sat);
            if (sel) q9.push_back({ov, 1'(hi_f), r});
            else     q16.push_back({ov, 8'(hi_f), r});
            m_beat[sel] = 0;
            m_hi[sel]   = 0;
            m_ovf[sel]  = 1'b0;
        end else begin
            m_beat[sel]++;
            if (c) begin
                if (sat) m_ovf[sel] = 1'b1;
                else     m_hi[sel]++;
            end
        end
        @(negedge clk);
    endtask

    // Wait for the selected FIFO head, compare it with the oldest expected
    // entry, then pop it with a one-cycle out_ready pulse.
    task automatic checkOutput(input bit sel, input string tag);
        int          n;
        logic [16:0] e16;
        logic [9:0]  e9;
        n = 0;
        while (((sel ? out_valid9 : out_valid) !== 1'b1) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check({tag, " out_valid"}, {31'b0, (sel ? out_valid9 : out_valid)}, 32'd1);
        if (sel) begin
            if (q9.size() > 0) begin
                e9 = q9.pop_front();
                check({tag, " out_sum"}, {23'b0, out_sum9}, {23'b0, e9[8:0]});
                check({tag, " out_ovf"}, {31'b0, out_ovf9}, {31'b0, e9[9]});
            end
            out_ready9 = 1'b1;
        end else begin
            if (q16.size() > 0) begin
                e16 = q16.pop_front();
                check({tag, " out_sum"}, {16'b0, out_sum}, {16'b0, e16[15:0]});
                check({tag, " out_ovf"}, {31'b0, out_ovf}, {31'b0, e16[16]});
            end
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        out_ready  = 1'b0;
        out_ready9 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        resetModel();

        // Reset asserted between clock edges must act at once.
        #2 rst = 1'b1;
        #1;
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset in_ready", {31'b0, in_ready}, 32'd1);
        check("reset mac_clr", {31'b0, mac_clr}, 32'd0);
        check("reset out_sum", {16'b0, out_sum}, 32'd0);
        check("reset out_ovf", {31'b0, out_ovf}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Frame with one carry: 2, +30, +225 (carry), +120 -> 0x0179.
        applyStimulus(0, 8'h02, 1'b0);
        applyStimulus(0, 8'h20, 1'b0);
        applyStimulus(0, 8'h01, 1'b1);
        applyStimulus(0, 8'h79, 1'b0);
        check("clr cycle mac_clr", {31'b0, mac_clr}, 32'd1);
        check("clr cycle in_ready", {31'b0, in_ready}, 32'd0);
        check("clr cycle out_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check("after clr mac_clr", {31'b0, mac_clr}, 32'd0);
        check("after clr in_ready", {31'b0, in_ready}, 32'd1);
        check("push latency out_valid", {31'b0, out_valid}, 32'd1);
        checkOutput(0, "carry frame");

        // Frame without carries.
        applyStimulus(0, 8'h01, 1'b0);
        applyStimulus(0, 8'h03, 1'b0);
        applyStimulus(0, 8'h06, 1'b0);
        applyStimulus(0, 8'h0A, 1'b0);
        checkOutput(0, "no carry frame");

        // Backpressure: two frames fill the FIFO, the third frame's last
        // beat stalls until the head is popped.
        applyStimulus(0, 8'h40, 1'b0);
        applyStimulus(0, 8'h80, 1'b1);
        applyStimulus(0, 8'hF0, 1'b0);
        applyStimulus(0, 8'h11, 1'b0);
        applyStimulus(0, 8'h10, 1'b1);
        applyStimulus(0, 8'h18, 1'b0);
        applyStimulus(0, 8'h20, 1'b0);
        applyStimulus(0, 8'h22, 1'b1);
        applyStimulus(0, 8'h30, 1'b0);
        applyStimulus(0, 8'h31, 1'b0);
        applyStimulus(0, 8'h32, 1'b0);
        mac_result = 8'h33;
        mac_cout   = 1'b0;
        in_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall in_ready", {31'b0, in_ready}, 32'd0);
            check("stall out_valid", {31'b0, out_valid}, 32'd1);
            check("stall out_sum", {16'b0, out_sum}, {16'b0, q16[0][15:0]});
        end
        checkOutput(0, "stalled frame 1");
        applyStimulus(0, 8'h33, 1'b0);
        checkOutput(0, "stalled frame 2");
        checkOutput(0, "stalled frame 3");
        check("drained out_valid", {31'b0, out_valid}, 32'd0);

        // Saturation on the 9-bit instance: three carries in one frame.
        applyStimulus(1, 8'h11, 1'b1);
        applyStimulus(1, 8'h22, 1'b1);
        applyStimulus(1, 8'h33, 1'b1);
        applyStimulus(1, 8'h55, 1'b0);
        checkOutput(1, "saturated frame");
        applyStimulus(1, 8'h01, 1'b0);
        applyStimulus(1, 8'h02, 1'b1);
        applyStimulus(1, 8'h03, 1'b0);
        applyStimulus(1, 8'h07, 1'b0);
        checkOutput(1, "post saturation frame");

        // Reset mid-frame with a finished frame still queued.
        applyStimulus(0, 8'h01, 1'b0);
        applyStimulus(0, 8'h02, 1'b0);
        applyStimulus(0, 8'h03, 1'b0);
        applyStimulus(0, 8'h04, 1'b0);
        applyStimulus(0, 8'h90, 1'b1);
        applyStimulus(0, 8'hA0, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("midframe reset out_valid", {31'b0, out_valid}, 32'd0);
        check("midframe reset out_sum", {16'b0, out_sum}, 32'd0);
        check("midframe reset mac_clr", {31'b0, mac_clr}, 32'd0);
        check("midframe reset in_ready", {31'b0, in_ready}, 32'd1);
        resetModel();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(0, 8'h10, 1'b0);
        applyStimulus(0, 8'h20, 1'b0);
        applyStimulus(0, 8'h30, 1'b0);
        applyStimulus(0, 8'h44, 1'b0);
        checkOutput(0, "frame after reset");
        check("final out_valid", {31'b0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_result_collector.md
Name: mac_result_collector

Overview:
- Downstream stage of the 4-bit array-multiplier / Kogge-Stone-adder MAC.
- Consumes the MAC's 8-bit running result and its carry-out on every valid beat, and extends the sum to EXT_W bits by counting carry-outs.
- After TERMS beats it packs the extended sum into a 2-entry output FIFO with a valid/ready handshake.
- It then pulses a clear to the MAC so the next dot-product frame starts from zero.

Parameters:
- TERMS, 4, number of MAC beats per frame (2..255).
- EXT_W, 16, width of the extended sum (9..24); the upper EXT_W-8 bits come from the carry counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  MAC produced a new accumulation this cycle.
- in_ready  out  1  collector accepts a beat this cycle; the beat is taken on in_valid & in_ready.
- mac_result  in  8  MAC running result after this beat's accumulation.
- mac_cout  in  1  high on the beat whose accumulation carried out of bit 7.
- mac_clr  out  1  one-cycle pulse that clears the MAC accumulator.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer takes the head on out_valid & out_ready.
- out_sum  out  EXT_W  extended frame sum {carry count, mac_result}.
- out_ovf  out  1  sticky overflow for this frame: the carry counter saturated.

Behaviour:
- Reset (async assert, sync release) sets state ACC, beat_cnt=0, hi_cnt=0, ovf=0, FIFO empty, in_ready=1, mac_clr=0, out_valid=0, out_sum=0, out_ovf=0.
- States: ACC and CLR.
- ACC, accepted beat that is not the last (beat_cnt<TERMS-1):
  - beat_cnt++.
  - If mac_cout, then hi_cnt++, saturating at 2^(EXT_W-8)-1.
  - Incrementing while already saturated sets ovf.
- ACC, accepted last beat (beat_cnt==TERMS-1):
  - Push {hi_cnt+mac_cout (saturated), mac_result}, with ovf|sat, into the FIFO.
  - Clear beat_cnt, hi_cnt and ovf.
  - Go to CLR.
- CLR: mac_clr=1 and in_ready=0 for exactly one cycle, then return to ACC. Beats presented during CLR are not taken.
- in_ready = (state==ACC) & !(beat_cnt==TERMS-1 & fifo_full).
  - Mid-frame beats are never stalled.
  - Only the last beat waits for FIFO space, so a frame is never dropped.
- FIFO:
  - 2 entries, registered head; out_sum and out_ovf are driven directly from the head entry.
  - Push-to-out_valid latency is 1 cycle. Last beat accepted at edge N gives out_valid=1 after edge N+1.
  - A push and a pop in the same cycle are both allowed when full or empty-pending; count is unchanged.
  - out_sum and out_ovf hold stable while out_valid & !out_ready.
  - When the FIFO is empty, out_valid=0 and out_sum/out_ovf hold their last value (0 after reset).
- Arithmetic: unsigned. mac_result is used verbatim as the low byte. The carry counter never wraps.
- Reset mid-frame: the partial frame is discarded, the FIFO is flushed, and mac_clr is not pulsed. The MAC has its own reset.
- A beat with in_valid=1 while in_ready=0 is ignored; upstream must hold it.

Decomposition:
- Shared package mac_pkg holds:
  - MAC_RES_W=8.
  - Default TERMS and EXT_W.
  - The state encoding (ACC=0, CLR=1).
  - The FIFO entry struct/concatenation layout {ovf, sum}.
- One sub-module: mac_sum_fifo, a 2-deep valid/ready FIFO of width EXT_W+1. The FSM, beat counter and carry counter stay in mac_result_collector.

Test Plan:
1. Reset: assert rst mid-cycle with no clock edge -> out_valid=0, in_ready=1, mac_clr=0, out_sum=0 immediately.
2. Frame with carry:
   - Stimulus: TERMS=4, out_ready=1; beats (result,cout) = (0x02,0),(0x20,0),(0x01,1),(0x79,0), i.e. products 2,30,225,120.
   - Response: one entry with out_sum=0x0179 (377) and out_ovf=0; mac_clr high for one cycle after the last beat; in_ready low in that cycle.
3. No carry: four beats ending at 0x0A with all cout=0 -> out_sum=0x000A, out_ovf=0.
4. Backpressure:
   - Stimulus: out_ready=0; run three frames back to back.
   - Response: two entries are held; the 4th beat of frame 3 sees in_ready=0 until out_ready=1 pops the head. Outputs come out in order with values unchanged while stalled.
5. Saturation: EXT_W=9, three cout=1 beats in one frame -> upper bit saturates at 1 and out_ovf=1; the next frame starts with ovf=0.
6. Reset mid-frame: after 2 beats, pulse rst, then run a full frame -> only the new frame's sum is produced, with no stale carry count.
